change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 23 ++
 rtl/change_dispenser_coin_select.sv | 34 +++
 rtl/en_reg.sv | 18 +
 rtl/change_dispenser.sv | 122 ++++++++++++
 tb/tb_change_dispenser.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared encodings for the change dispenser: FSM states, coin codes and
// default coin values (in 5-cent units).
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_e;

  localparam int DEF_NICKEL_VAL  = 1;
  localparam int DEF_DIME_VAL    = 2;
  localparam int DEF_QUARTER_VAL = 5;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest coin not exceeding the balance, plus its value.
module coin_select
  import change_dispenser_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int NICKEL_VAL  = DEF_NICKEL_VAL,
  parameter int DIME_VAL    = DEF_DIME_VAL,
  parameter int QUARTER_VAL = DEF_QUARTER_VAL
) (
  input  logic [WIDTH-1:0] rem_i,
  output coin_e            type_o,
  output logic [WIDTH-1:0] val_o
);

  localparam logic [WIDTH-1:0] NV = WIDTH'(NICKEL_VAL);
  localparam logic [WIDTH-1:0] DV = WIDTH'(DIME_VAL);
  localparam logic [WIDTH-1:0] QV = WIDTH'(QUARTER_VAL);

  always_comb begin
    type_o = COIN_NONE;
    val_o  = '0;
    if (rem_i >= QV) begin
      type_o = COIN_QUARTER;
      val_o  = QV;
    end else if (rem_i >= DV) begin
      type_o = COIN_DIME;
      val_o  = DV;
    end else if (rem_i >= NV) begin
      type_o = COIN_NICKEL;
      val_o  = NV;
    end
  end

endmodule

// File: rtl/en_reg.sv
// Generic WIDTH-bit register with load enable and async active-low reset.
module en_reg #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a credit as a greedy coin sequence with a
// valid/ack handshake to the hopper. All outputs come straight from flops.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int NICKEL_VAL  = DEF_NICKEL_VAL,
  parameter int DIME_VAL    = DEF_DIME_VAL,
  parameter int QUARTER_VAL = DEF_QUARTER_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic             abort,
  input  logic             coin_ack,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  coin_e            coin_type_q, sel_type;
  logic             coin_valid_q, busy_q, done_q;
  logic [WIDTH-1:0] rem_q, rem_d, sel_val;
  logic             rem_en, kill, ack_take;

  // Balance is stable from SELECT through DISPENSE, so the same combinational
  // pick serves both the registered coin_type and the subtraction on ack.
  coin_select #(
    .WIDTH(WIDTH), .NICKEL_VAL(NICKEL_VAL), .DIME_VAL(DIME_VAL), .QUARTER_VAL(QUARTER_VAL)
  ) u_sel (
    .rem_i (rem_q),
    .type_o(sel_type),
    .val_o (sel_val)
  );

  assign kill     = abort && (state_q != IDLE);
  assign ack_take = (state_q == DISPENSE) && coin_ack && !abort;

  always_comb begin
    rem_en = 1'b0;
    rem_d  = rem_q;
    if (kill) begin
      rem_en = 1'b1;
      rem_d  = '0;
    end else if (state_q == IDLE && start && !abort) begin
      rem_en = 1'b1;
      rem_d  = amount;
    end else if (ack_take) begin
      rem_en = 1'b1;
      rem_d  = rem_q - sel_val;
    end
  end

  en_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_rem (
    .clk  (clk),
    .rst_n(rst),
    .en_i (rem_en),
    .d_i  (rem_d),
    .q_o  (rem_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      coin_valid_q <= 1'b0;
      coin_type_q  <= COIN_NONE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        state_q      <= IDLE;
        coin_valid_q <= 1'b0;
        coin_type_q  <= COIN_NONE;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start && !abort) begin
            busy_q <= 1'b1;
            if (amount == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SELECT;
            end
          end
          SELECT: begin
            coin_type_q  <= sel_type;
            coin_valid_q <= 1'b1;
            state_q      <= DISPENSE;
          end
          DISPENSE: if (coin_ack) begin
            coin_valid_q <= 1'b0;
            coin_type_q  <= COIN_NONE;
            if (rem_q == sel_val) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SELECT;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_type  = coin_type_q;
  assign remaining  = rem_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy model queues the expected
// coin sequence at start; each presented coin pops and compares one entry.
module tb_change_dispenser;

  localparam int W = 5;

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, coin_ack = 1'b0;
  logic [W-1:0] amount = '0;
  logic         coin_valid, busy, done;
  logic [1:0]   coin_type;
  logic [W-1:0] remaining;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [1:0] typ;
    int         rem;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  change_dispenser #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .amount    (amount),
    .abort     (abort),
    .coin_ack  (coin_ack),
    .coin_valid(coin_valid),
    .coin_type (coin_type),
    .remaining (remaining),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] gcoin(input int r);
    if (r >= 5)      return 2'b11;
    else if (r >= 2) return 2'b10;
    else if (r >= 1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int cval(input logic [1:0] t);
    case (t)
      2'b11:   return 5;
      2'b10:   return 2;
      2'b01:   return 1;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; coin_ack = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  // abort_at / rst_at: coin index at which to abort (with its ack) or reset; -1 = never
  task automatic pay(input int amt, input int ack_dly, input int abort_at, input int rst_at,
                     input bit restart);
    int   r, idx, cnt;
    exp_t e;
    r = amt;
    while (r > 0) begin
      e.typ = gcoin(r);
      e.rem = r;
      exp_q.push_back(e);
      r -= cval(e.typ);
    end
    start = 1'b1; amount = W'(amt);
    step();
    start = 1'b0;
    if (restart) begin
      start = 1'b1; amount = W'(3);
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      cnt = 1;
      while (!coin_valid && cnt < 8) begin
        chk("type_when_invalid", coin_type, 0);
        step();
        start = 1'b0;
        cnt++;
      end
      start = 1'b0;
      chk("coin_latency", cnt, 2);
      if (!coin_valid) begin
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      chk("coin_type", coin_type, e.typ);
      chk("remaining", remaining, e.rem);
      if (idx == rst_at) begin
        #2 rst = 1'b0;
        #1 chk("outs_in_reset", {coin_valid, coin_type, remaining, busy, done}, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("idle_after_reset", {busy, coin_valid, done}, 0);
        step();
        chk("stay_idle_after_reset", {busy, coin_valid, remaining}, 0);
        exp_q.delete();
        return;
      end
      for (int k = 0; k < ack_dly; k++) begin
        step();
        chk("hold_valid", coin_valid, 1);
        chk("hold_type", coin_type, e.typ);
      end
      coin_ack = 1'b1;
      abort    = (idx == abort_at);
      step();
      coin_ack = 1'b0;
      if (abort) begin
        abort = 1'b0;
        chk("abort_state", {busy, coin_valid, coin_type, remaining, done}, 0);
        for (int k = 0; k < 3; k++) begin
          step();
          chk("abort_no_done", {done, coin_valid, busy}, 0);
        end
        exp_q.delete();
        return;
      end
      idx++;
    end
    chk("done_pulse", done, 1);
    chk("final_remaining", remaining, 0);
    chk("valid_in_done", coin_valid, 0);
    step();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    #2;
    chk("reset_outs", {coin_valid, coin_type, remaining, busy, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    pay(13, 1, -1, -1, 1'b0);
    do_reset();
    pay(0, 0, -1, -1, 1'b0);
    do_reset();
    pay(7, 4, -1, -1, 1'b0);
    do_reset();
    pay(31, 0, -1, -1, 1'b1);
    do_reset();
    pay(9, 0, 0, -1, 1'b0);
    do_reset();
    pay(12, 1, -1, 1, 1'b0);
    pay(2, 0, -1, -1, 1'b0);

    // start together with abort in IDLE must be ignored
    start = 1'b1; abort = 1'b1; amount = W'(6);
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {busy, remaining}, 0);
    step();
    chk("start_abort_idle2", {busy, coin_valid, done}, 0);

    // ack and abort while idle are no-ops
    coin_ack = 1'b1; abort = 1'b1;
    step();
    coin_ack = 1'b0; abort = 1'b0;
    chk("idle_ack_abort", {busy, coin_valid, remaining, done}, 0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      pay($urandom_range(1, 31), $urandom_range(0, 3), -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
